// File: rtl/counter_bank.sv
// Register-bus bank of event counters: per-channel enable, wrap/saturate, sticky OVF, clear, coherent snapshot.
// Writes take effect on the next clk_i edge, reads are combinational; no handshake, never stalls.
module counter_bank #(
   parameter logic [15:0] BASE_ADDR  = 16'h0040,
   parameter int          N_CHANNELS = 8,
   parameter int          WIDTH      = 32,
   parameter bit          SATURATE   = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [15:0]           reg_addr_i,
   inout  wire  [31:0]           reg_data_io,
   input  logic                  reg_wr_i,
   input  logic [N_CHANNELS-1:0] events_i
);

   localparam logic [15:0] LAST_OFF = 16'(N_CHANNELS + 2);

   logic [15:0]           w_off;
   logic                  w_in_range;
   logic                  w_wr;
   logic                  w_rd_en;
   logic [31:0]           w_wr_dat;
   logic [31:0]           w_rd_dat;
   logic                  w_ctrl_wr;
   logic                  w_ovf_wr;
   logic                  w_en_wr;
   logic                  w_snap_all;
   logic                  w_clr_all;
   logic                  w_unused;
   logic [N_CHANNELS-1:0] w_snap_wr;
   logic [N_CHANNELS-1:0] w_inc;
   logic [N_CHANNELS-1:0] w_at_max;
   logic [N_CHANNELS-1:0] w_cnt_clr;
   logic [N_CHANNELS-1:0] w_ovf_set;
   logic [N_CHANNELS-1:0] w_ovf_clr;

   logic [WIDTH-1:0]      r_cnt  [N_CHANNELS];
   logic [WIDTH-1:0]      r_snap [N_CHANNELS];
   logic [N_CHANNELS-1:0] r_ovf;
   logic [N_CHANNELS-1:0] r_en;

   assign w_off      = reg_addr_i - BASE_ADDR;
   assign w_in_range = (reg_addr_i >= BASE_ADDR) && (w_off <= LAST_OFF);
   assign w_wr       = reg_wr_i && w_in_range;
   assign w_rd_en    = !reg_wr_i && w_in_range;
   assign w_wr_dat   = reg_data_io;
   assign w_unused   = ^w_wr_dat;

   assign w_ctrl_wr  = w_wr && (w_off == 16'd0);
   assign w_ovf_wr   = w_wr && (w_off == 16'd1);
   assign w_en_wr    = w_wr && (w_off == 16'd2);
   assign w_snap_all = w_ctrl_wr && w_wr_dat[0];
   assign w_clr_all  = w_ctrl_wr && w_wr_dat[1];

   // A clear on the same edge as an event discards the event, so it cannot raise OVF either.
   always_comb begin
      w_snap_wr = '0;
      w_inc     = '0;
      w_at_max  = '0;
      w_cnt_clr = '0;
      w_ovf_set = '0;
      w_ovf_clr = '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
         w_snap_wr[k] = w_wr && (w_off == 16'(k + 3));
         w_inc[k]     = events_i[k] && r_en[k];
         w_at_max[k]  = &r_cnt[k];
         w_cnt_clr[k] = w_clr_all || w_snap_wr[k];
         w_ovf_set[k] = w_inc[k] && w_at_max[k] && !w_cnt_clr[k];
         w_ovf_clr[k] = w_snap_wr[k] || (w_ovf_wr && w_wr_dat[k]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int k = 0; k < N_CHANNELS; k++) begin
            r_cnt[k]  <= '0;
            r_snap[k] <= '0;
         end
         r_ovf <= '0;
         r_en  <= '1;
      end else begin
         for (int k = 0; k < N_CHANNELS; k++) begin
            if (w_snap_all) r_snap[k] <= r_cnt[k];
            if (w_cnt_clr[k]) begin
               r_cnt[k] <= '0;
            end else if (w_inc[k]) begin
               if (!w_at_max[k])  r_cnt[k] <= r_cnt[k] + WIDTH'(1);
               else if (!SATURATE) r_cnt[k] <= '0;
            end
         end
         // Set beats W1C on the same edge.
         r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
         if (w_en_wr) r_en <= w_wr_dat[N_CHANNELS-1:0];
      end
   end

   always_comb begin
      w_rd_dat = '0;
      if (w_off == 16'd1) w_rd_dat[N_CHANNELS-1:0] = r_ovf;
      if (w_off == 16'd2) w_rd_dat[N_CHANNELS-1:0] = r_en;
      for (int k = 0; k < N_CHANNELS; k++) begin
         if (w_off == 16'(k + 3)) w_rd_dat[WIDTH-1:0] = r_snap[k];
      end
   end

   assign reg_data_io = w_rd_en ? w_rd_dat : 'z;

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboarded bench: wrap and saturate instances share stimulus and are checked against an integer model.
module tb_counter_bank;

   localparam logic [15:0] BASE = 16'h0040;
   localparam int N    = 8;
   localparam int W    = 4;
   localparam int MAXV = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic        wr = 1'b0;
   logic [31:0] wdat = 32'h0;
   logic [7:0]  ev = 8'h00;
   logic        rd_req = 1'b0;
   wire  [31:0] bus0;
   wire  [31:0] bus1;

   always #5 clk = ~clk;

   assign bus0 = wr ? wdat : 32'bz;
   assign bus1 = wr ? wdat : 32'bz;

   counter_bank #(.BASE_ADDR(BASE), .N_CHANNELS(N), .WIDTH(W), .SATURATE(1'b0)) dut_wrap (
      .clk_i(clk), .reset_i(rst), .reg_addr_i(addr), .reg_data_io(bus0),
      .reg_wr_i(wr), .events_i(ev));

   counter_bank #(.BASE_ADDR(BASE), .N_CHANNELS(N), .WIDTH(W), .SATURATE(1'b1)) dut_sat (
      .clk_i(clk), .reset_i(rst), .reg_addr_i(addr), .reg_data_io(bus1),
      .reg_wr_i(wr), .events_i(ev));

   // Reference state, index [0]=wrap, [1]=saturate
   int       m_cnt  [2][N];
   int       m_snap [2][N];
   bit [7:0] m_ovf  [2];
   bit [7:0] m_en = 8'hFF;

   int tests = 0;
   int fails = 0;

   string       q_name[$];
   logic [31:0] q_e0[$];
   logic [31:0] q_e1[$];
   bit          q_z[$];

   function automatic void model_step();
      bit ctrl, ovfw, enw, snapw;
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N; k++) begin
               m_cnt[m][k]  = 0;
               m_snap[m][k] = 0;
            end
            m_ovf[m] = 8'h00;
         end
         m_en = 8'hFF;
         return;
      end
      ctrl = wr && (addr == BASE);
      ovfw = wr && (addr == BASE + 16'd1);
      enw  = wr && (addr == BASE + 16'd2);
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < N; k++) begin
            snapw = wr && (addr == BASE + 16'(3 + k));
            if (ctrl && wdat[0]) m_snap[m][k] = m_cnt[m][k];
            if ((ovfw && wdat[k]) || snapw) m_ovf[m][k] = 1'b0;
            if ((ctrl && wdat[1]) || snapw) begin
               m_cnt[m][k] = 0;
            end else if (ev[k] && m_en[k]) begin
               if (m_cnt[m][k] == MAXV) begin
                  m_ovf[m][k] = 1'b1;
                  m_cnt[m][k] = (m == 1) ? MAXV : 0;
               end else begin
                  m_cnt[m][k] = m_cnt[m][k] + 1;
               end
            end
         end
      end
      if (enw) m_en = wdat[7:0];
   endfunction

   function automatic bit in_range(logic [15:0] a);
      return (a >= BASE) && (a <= BASE + 16'(N + 2));
   endfunction

   function automatic logic [31:0] model_read(int m, logic [15:0] a);
      if (a == BASE + 16'd1) return {24'h0, m_ovf[m]};
      if (a == BASE + 16'd2) return {24'h0, m_en};
      for (int k = 0; k < N; k++)
         if (a == BASE + 16'(3 + k)) return 32'(m_snap[m][k]);
      return 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(int n);
      addr = 16'h0000;
      wr   = 1'b0;
      repeat (n) tick();
   endtask

   task automatic wr_reg(logic [15:0] a, logic [31:0] d);
      addr = a;
      wr   = 1'b1;
      wdat = d;
      tick();
      wr   = 1'b0;
      addr = 16'h0000;
   endtask

   task automatic push(string nm, logic [31:0] e0, logic [31:0] e1, bit z);
      q_name.push_back(nm);
      q_e0.push_back(e0);
      q_e1.push_back(e1);
      q_z.push_back(z);
   endtask

   task automatic rd_model(logic [15:0] a, string nm);
      addr   = a;
      wr     = 1'b0;
      rd_req = 1'b1;
      if (in_range(a)) push(nm, model_read(0, a), model_read(1, a), 1'b0);
      else             push(nm, 32'h0, 32'h0, 1'b1);
      tick();
      rd_req = 1'b0;
      addr   = 16'h0000;
   endtask

   task automatic rd_exp(logic [15:0] a, string nm, logic [31:0] e0, logic [31:0] e1);
      addr   = a;
      wr     = 1'b0;
      rd_req = 1'b1;
      push(nm, e0, e1, 1'b0);
      tick();
      rd_req = 1'b0;
      addr   = 16'h0000;
   endtask

   // Monitor: reads are combinational, so the response is present mid-cycle.
   always @(negedge clk) begin
      string       nm;
      logic [31:0] e0, e1;
      bit          z;
      if (rd_req) begin
         if (q_name.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_read addr=%h got wrap=%h sat=%h required=no read", addr, bus0, bus1);
         end else begin
            nm = q_name.pop_front();
            e0 = q_e0.pop_front();
            e1 = q_e1.pop_front();
            z  = q_z.pop_front();
            tests += 2;
            if (z) begin
               if (bus0 !== 32'bz) begin
                  fails++;
                  $display("FAIL %s wrap: got %h required zzzzzzzz", nm, bus0);
               end
               if (bus1 !== 32'bz) begin
                  fails++;
                  $display("FAIL %s sat: got %h required zzzzzzzz", nm, bus1);
               end
            end else begin
               if (bus0 !== e0) begin
                  fails++;
                  $display("FAIL %s wrap: got %h required %h", nm, bus0, e0);
               end
               if (bus1 !== e1) begin
                  fails++;
                  $display("FAIL %s sat: got %h required %h", nm, bus1, e1);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      int          op;

      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      rd_exp(BASE + 16'd2, "rst_en", 32'hFF, 32'hFF);
      rd_exp(BASE + 16'd1, "rst_ovf", 32'h0, 32'h0);
      rd_exp(BASE + 16'd3, "rst_snap0", 32'h0, 32'h0);
      rd_exp(BASE, "ctrl_reads_zero", 32'h0, 32'h0);
      rd_model(16'h0000, "oor_low");
      rd_model(BASE - 16'd1, "oor_below_base");
      rd_model(BASE + 16'd11, "oor_above_last");

      ev = 8'h04;
      idle(5);
      ev = 8'h00;
      wr_reg(BASE, 32'h1);
      rd_exp(BASE + 16'd5, "snap2_burst", 32'd5, 32'd5);
      rd_exp(BASE + 16'd4, "snap1_idle", 32'd0, 32'd0);

      ev = 8'h01;
      wr_reg(BASE, 32'h1);
      ev = 8'h00;
      rd_exp(BASE + 16'd3, "snap_excludes_same_edge", 32'd0, 32'd0);
      wr_reg(BASE, 32'h1);
      rd_exp(BASE + 16'd3, "snap_next_includes", 32'd1, 32'd1);

      wr_reg(BASE + 16'd3, 32'h0);
      ev = 8'h01;
      idle(17);
      ev = 8'h00;
      wr_reg(BASE, 32'h1);
      rd_exp(BASE + 16'd3, "ovf_17_events", 32'd1, 32'd15);
      rd_exp(BASE + 16'd1, "ovf_sticky", 32'h1, 32'h1);
      wr_reg(BASE + 16'd1, 32'h1);
      rd_exp(BASE + 16'd1, "ovf_w1c", 32'h0, 32'h0);

      ev = 8'h08;
      idle(7);
      ev = 8'h00;
      wr_reg(BASE, 32'h3);
      rd_exp(BASE + 16'd6, "read_and_clear_snap", 32'd7, 32'd7);
      wr_reg(BASE, 32'h1);
      rd_exp(BASE + 16'd6, "read_and_clear_zeroed", 32'd0, 32'd0);
      ev = 8'h08;
      wr_reg(BASE + 16'd6, 32'hDEAD_BEEF);
      ev = 8'h00;
      wr_reg(BASE, 32'h1);
      rd_exp(BASE + 16'd6, "clear_beats_event", 32'd0, 32'd0);

      ev = 8'h01;
      wr_reg(BASE + 16'd2, 32'hFFFF_FFFE);
      idle(3);
      ev = 8'h00;
      wr_reg(BASE, 32'h1);
      rd_exp(BASE + 16'd3, "en_old_mask_on_write_edge", 32'd1, 32'd1);
      rd_exp(BASE + 16'd2, "en_upper_bits_ignored", 32'hFE, 32'hFE);

      wr_reg(BASE + 16'd2, 32'hFF);
      ev = 8'h02;
      idle(15);
      wr_reg(BASE + 16'd1, 32'hFFFF_FF02);
      ev = 8'h00;
      rd_exp(BASE + 16'd1, "ovf_set_beats_w1c", 32'h2, 32'h2);

      ev = 8'hFF;
      idle(3);
      wr_reg(BASE, 32'h1);
      idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      ev = 8'h00;
      rd_exp(BASE + 16'd2, "midburst_rst_en", 32'hFF, 32'hFF);
      rd_exp(BASE + 16'd1, "midburst_rst_ovf", 32'h0, 32'h0);
      for (int k = 0; k < N; k++) rd_exp(BASE + 16'(3 + k), $sformatf("midburst_rst_snap%0d", k), 32'h0, 32'h0);
      wr_reg(BASE, 32'h1);
      for (int k = 0; k < N; k++) rd_exp(BASE + 16'(3 + k), $sformatf("midburst_rst_cnt%0d", k), 32'h0, 32'h0);

      for (int i = 0; i < 600; i++) begin
         ev  = 8'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         a   = BASE - 16'd2 + 16'($urandom_range(0, 14));
         op  = $urandom_range(0, 9);
         if (op < 2)      idle(1);
         else if (op < 5) wr_reg(a, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
         else             rd_model(a, $sformatf("rand_rd_%h", a));
         rst = 1'b0;
      end

      ev = 8'h00;
      wr_reg(BASE, 32'h1);
      for (int k = 0; k < N; k++) rd_model(BASE + 16'(3 + k), $sformatf("final_snap%0d", k));
      rd_model(BASE + 16'd1, "final_ovf");
      rd_model(BASE + 16'd2, "final_en");
      idle(2);

      tests++;
      if (q_name.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", q_name.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
